// File: rtl/dup_seq_ctrl.sv
// Load / run / pause / terminate sequencer that owns a WIDTH-bit count register.
// Counts from a captured load value toward a captured terminal value in a captured direction.
module dup_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cnt,
                                                   input logic dir);
    return dir ? (cnt + ONE) : (cnt - ONE);
  endfunction

  function automatic logic step_wraps(input logic [WIDTH-1:0] cnt, input logic dir);
    return dir ? (cnt == CNT_MAX) : (cnt == '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      term_q  <= '0;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = load_val;
          term_d  = term;
          dir_d   = up_dn;
        end
      end
      S_LOAD: begin
        if (stop)                 state_d = S_IDLE;
        else if (cnt_q == term_q) state_d = S_DONE;
        else                      state_d = S_RUN;
      end
      // Priority: stop, then pause, then terminal match, and only then a step.
      S_RUN: begin
        if (stop)                 state_d = S_IDLE;
        else if (pause)           state_d = S_PAUSE;
        else if (cnt_q == term_q) state_d = S_DONE;
        else begin
          cnt_d  = step_count(cnt_q, dir_q);
          wrap_d = step_wraps(cnt_q, dir_q);
        end
      end
      // Resume edge only returns to RUN; the next step happens one edge later.
      S_PAUSE: begin
        if (stop)        state_d = S_IDLE;
        else if (!pause) state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign q    = cnt_q;
  assign busy = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done = (state_q == S_DONE);
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dup_seq_ctrl.sv
// Bench for dup_seq_ctrl: directed scenarios plus random traffic, all checked
// against a phase-based reference model of the sequencing rules.
module tb_dup_seq_ctrl;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stop, pause, up_dn;
  logic [W-1:0] load_val, term;
  logic [W-1:0] q;
  logic         busy, done, wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 load, 2 run, 3 pause, 4 done
  int ph, mq, mterm, mdir, mwrap;

  dup_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .up_dn(up_dn), .load_val(load_val), .term(term),
    .q(q), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    ph = 0; mq = 0; mterm = 0; mdir = 1; mwrap = 0;
  endtask

  task automatic model_step();
    int nph, nq, nw;
    nph = ph; nq = mq; nw = 0;
    if (rst) begin
      model_reset();
      return;
    end
    case (ph)
      0: if (start) begin
           nph = 1; nq = int'(load_val); mterm = int'(term); mdir = int'(up_dn);
         end
      1: if (stop) nph = 0; else if (mq == mterm) nph = 4; else nph = 2;
      2: if (stop) nph = 0;
         else if (pause) nph = 3;
         else if (mq == mterm) nph = 4;
         else if (mdir != 0) begin nq = (mq + 1) % MOD; nw = (mq == MOD - 1); end
         else begin nq = (mq + MOD - 1) % MOD; nw = (mq == 0); end
      3: if (stop) nph = 0; else if (!pause) nph = 2;
      default: nph = 0;
    endcase
    ph = nph; mq = nq; mwrap = nw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " q"},    32'(q),    32'(mq));
    chk({tag, " busy"}, 32'(busy), 32'((ph >= 1) && (ph <= 3)));
    chk({tag, " done"}, 32'(done), 32'(ph == 4));
    chk({tag, " wrap"}, 32'(wrap), 32'(mwrap));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa, input logic ud,
                       input logic [W-1:0] lv, input logic [W-1:0] tm);
    start = st; stop = sp; pause = pa; up_dn = ud; load_val = lv; term = tm;
  endtask

  initial begin
    int t2q[5];
    int t3q[5];
    t2q = '{2, 2, 3, 4, 5};
    t3q = '{14, 14, 15, 0, 1};
    rst = 1'b1;
    drive(0, 0, 0, 0, '0, '0);
    model_reset();
    #12;
    chk_all("reset");
    rst = 1'b0;

    // Up count 2 -> 5 with exact cycle positions
    drive(1, 0, 0, 1, 4'd2, 4'd5);
    for (int i = 0; i < 5; i++) begin
      cyc("t2");
      start = 1'b0;
      chk("t2 q seq", 32'(q), 32'(t2q[i]));
    end
    cyc("t2");
    chk("t2 done pulse", 32'(done), 32'd1);
    cyc("t2");
    chk("t2 back idle", 32'(busy | done), 32'd0);

    // Up count through the 15 -> 0 wrap
    drive(1, 0, 0, 1, 4'd14, 4'd1);
    for (int i = 0; i < 5; i++) begin
      cyc("t3");
      start = 1'b0;
      chk("t3 q seq", 32'(q), 32'(t3q[i]));
      chk("t3 wrap", 32'(wrap), 32'(i == 3));
    end
    cyc("t3");
    chk("t3 done pulse", 32'(done), 32'd1);
    cyc("t3");

    // Down count with a three-cycle pause at q=2
    drive(1, 0, 0, 0, 4'd3, 4'd0);
    cyc("t4"); start = 1'b0;
    cyc("t4");
    cyc("t4");
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("t4 pause");
      chk("t4 hold", 32'(q), 32'd2);
    end
    pause = 1'b0;
    for (int i = 0; i < 5; i++) cyc("t4");

    // Load equals terminal: straight to done
    drive(1, 0, 0, 1, 4'd7, 4'd7);
    cyc("t5"); start = 1'b0;
    cyc("t5");
    chk("t5 done", 32'(done), 32'd1);
    chk("t5 q", 32'(q), 32'd7);
    cyc("t5");

    // Stop wins over pause; start during done is ignored
    drive(1, 0, 0, 1, 4'd0, 4'd9);
    cyc("t6"); start = 1'b0;
    cyc("t6");
    cyc("t6");
    stop = 1'b1; pause = 1'b1;
    cyc("t6 stop");
    chk("t6 stop busy", 32'(busy | done), 32'd0);
    stop = 1'b0; pause = 1'b0;
    drive(1, 0, 0, 1, 4'd5, 4'd5);
    cyc("t6b"); start = 1'b0;
    cyc("t6b");
    start = 1'b1;
    cyc("t6b");
    start = 1'b0;
    cyc("t6b");
    chk("t6 start in done ignored", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a run
    drive(1, 0, 0, 1, 4'd3, 4'd12);
    cyc("t1"); start = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t1");
    #2 rst = 1'b1;
    #1 model_reset();
    chk_all("t1 async rst");
    cyc("t1 rst held");
    rst = 1'b0;
    cyc("t1 after rst");

    // Random traffic against the model, with one async reset partway through
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 30) == 0, ($urandom % 6) == 0,
            1'($urandom), W'($urandom), W'($urandom_range(0, MOD - 1)));
      cyc("rand");
      if (i == 400) begin
        #2 rst = 1'b1;
        #1 model_reset();
        chk_all("rand async rst");
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
